// File: rtl/id_decode_pipe.sv
// Registered RV32I/RV64I (+M) instruction decoder for the ID stage.
// A decoded control bundle is captured on handshake and presented to EX
// through a two-entry skid buffer, so in_ready never depends on out_ready.
module id_decode_pipe #(
  parameter int XLEN     = 64,
  parameter int ENABLE_M = 1,
  parameter int PC_W     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            rs1_en,
  output logic            rs2_en,
  output logic            rd_en,
  output logic [2:0]      alu_op,
  output logic            alu_src_rs1,
  output logic            alu_src_imm,
  output logic [2:0]      gen_type,
  output logic [2:0]      comp_type,
  output logic [2:0]      shift_type,
  output logic            shift_imm,
  output logic [2:0]      load_type,
  output logic [2:0]      store_type,
  output logic            mem_read,
  output logic            mem_write,
  output logic            inst_word,
  output logic            inst_branch,
  output logic            inst_jump,
  output logic            inst_lui,
  output logic            muldiv_en,
  output logic [2:0]      muldiv_op,
  output logic            illegal
);

  localparam bit IS64 = (XLEN == 64);
  localparam bit HASM = (ENABLE_M != 0);

  typedef struct packed {
    logic       rs1En, rs2En, rdEn;
    logic [2:0] aluOp;
    logic       aluSrcRs1, aluSrcImm;
    logic [2:0] genType, compType, shiftType;
    logic       shiftImm;
    logic [2:0] loadType, storeType;
    logic       memRead, memWrite;
    logic       instWord, instBranch, instJump, instLui;
    logic       muldivEn;
    logic [2:0] muldivOp;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    ctrl_t           ctrl;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  ctrl_t  dec;
  logic   bad;
  logic   accept, pop, shamtOk;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign funct7  = in_inst[31:25];
  assign shamtOk = IS64 || !in_inst[25];

  // Combinational decode of the incoming instruction word into a control bundle
  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      7'b0110111: begin
        dec.rdEn = 1'b1; dec.aluSrcImm = 1'b1; dec.genType = 3'd4; dec.instLui = 1'b1;
      end
      7'b0010111: begin
        dec.rdEn = 1'b1; dec.aluOp = 3'd3; dec.aluSrcImm = 1'b1; dec.genType = 3'd4;
      end
      7'b1101111: begin
        dec.rdEn = 1'b1; dec.aluOp = 3'd3; dec.aluSrcImm = 1'b1; dec.genType = 3'd5;
        dec.instJump = 1'b1;
      end
      7'b1100111: begin
        dec.rs1En = 1'b1; dec.rdEn = 1'b1; dec.aluOp = 3'd3; dec.aluSrcRs1 = 1'b1;
        dec.aluSrcImm = 1'b1; dec.genType = 3'd6; dec.instJump = 1'b1;
        bad = (funct3 != 3'b000);
      end
      7'b1100011: begin
        dec.rs1En = 1'b1; dec.rs2En = 1'b1; dec.aluOp = 3'd4; dec.aluSrcRs1 = 1'b1;
        dec.genType = 3'd7; dec.instBranch = 1'b1;
        case (funct3)
          3'b000: dec.compType = 3'd2;
          3'b001: dec.compType = 3'd3;
          3'b100: dec.compType = 3'd4;
          3'b101: dec.compType = 3'd6;
          3'b110: dec.compType = 3'd5;
          3'b111: dec.compType = 3'd7;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.rs1En = 1'b1; dec.rdEn = 1'b1; dec.aluOp = 3'd3; dec.aluSrcRs1 = 1'b1;
        dec.aluSrcImm = 1'b1; dec.genType = 3'd6; dec.memRead = 1'b1;
        case (funct3)
          3'b000: dec.loadType = 3'd1;
          3'b001: dec.loadType = 3'd2;
          3'b010: dec.loadType = 3'd3;
          3'b011: begin dec.loadType = 3'd4; bad = !IS64; end
          3'b100: dec.loadType = 3'd5;
          3'b101: dec.loadType = 3'd6;
          3'b110: begin dec.loadType = 3'd7; bad = !IS64; end
          default: bad = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.rs1En = 1'b1; dec.rs2En = 1'b1; dec.aluOp = 3'd3; dec.aluSrcRs1 = 1'b1;
        dec.aluSrcImm = 1'b1; dec.genType = 3'd3; dec.memWrite = 1'b1;
        case (funct3)
          3'b000: dec.storeType = 3'd4;
          3'b001: dec.storeType = 3'd5;
          3'b010: dec.storeType = 3'd6;
          3'b011: begin dec.storeType = 3'd7; bad = !IS64; end
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.rs1En = 1'b1; dec.rdEn = 1'b1; dec.aluSrcRs1 = 1'b1;
        case (funct3)
          3'b000: begin dec.aluOp = 3'd3; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b010: begin dec.aluOp = 3'd4; dec.compType = 3'd4; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b011: begin dec.aluOp = 3'd4; dec.compType = 3'd5; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b100: begin dec.aluOp = 3'd5; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b110: begin dec.aluOp = 3'd6; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b111: begin dec.aluOp = 3'd7; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b001: begin
            dec.shiftType = 3'd1; dec.shiftImm = 1'b1;
            bad = (in_inst[31:26] != 6'b000000) || !shamtOk;
          end
          default: begin
            dec.shiftImm = 1'b1;
            if (in_inst[31:26] == 6'b000000 && shamtOk)      dec.shiftType = 3'd5;
            else if (in_inst[31:26] == 6'b010000 && shamtOk) dec.shiftType = 3'd4;
            else                                             bad = 1'b1;
          end
        endcase
      end
      7'b0011011: begin
        dec.rs1En = 1'b1; dec.rdEn = 1'b1; dec.aluSrcRs1 = 1'b1; dec.instWord = 1'b1;
        bad = !IS64;
        case (funct3)
          3'b000: begin dec.aluOp = 3'd3; dec.aluSrcImm = 1'b1; dec.genType = 3'd6; end
          3'b001: begin
            dec.shiftType = 3'd3; dec.shiftImm = 1'b1;
            if (funct7 != 7'b0000000) bad = 1'b1;
          end
          3'b101: begin
            dec.shiftImm = 1'b1;
            if (funct7 == 7'b0000000)      dec.shiftType = 3'd7;
            else if (funct7 == 7'b0100000) dec.shiftType = 3'd6;
            else                           bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0110011: begin
        dec.rs1En = 1'b1; dec.rs2En = 1'b1; dec.rdEn = 1'b1; dec.aluSrcRs1 = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: dec.aluOp = 3'd3;
              3'b001: dec.shiftType = 3'd1;
              3'b010: begin dec.aluOp = 3'd4; dec.compType = 3'd4; end
              3'b011: begin dec.aluOp = 3'd4; dec.compType = 3'd5; end
              3'b100: dec.aluOp = 3'd5;
              3'b101: dec.shiftType = 3'd5;
              3'b110: dec.aluOp = 3'd6;
              default: dec.aluOp = 3'd7;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.aluOp = 3'd4;
            else if (funct3 == 3'b101) dec.shiftType = 3'd4;
            else                       bad = 1'b1;
          end
          7'b0000001: begin
            dec.muldivEn = 1'b1; dec.muldivOp = funct3; bad = !HASM;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0111011: begin
        dec.rs1En = 1'b1; dec.rs2En = 1'b1; dec.rdEn = 1'b1; dec.aluSrcRs1 = 1'b1;
        dec.instWord = 1'b1;
        bad = !IS64;
        case (funct7)
          7'b0000000: begin
            if (funct3 == 3'b000)      dec.aluOp = 3'd3;
            else if (funct3 == 3'b001) dec.shiftType = 3'd3;
            else if (funct3 == 3'b101) dec.shiftType = 3'd7;
            else                       bad = 1'b1;
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.aluOp = 3'd4;
            else if (funct3 == 3'b101) dec.shiftType = 3'd6;
            else                       bad = 1'b1;
          end
          7'b0000001: begin
            dec.muldivEn = 1'b1; dec.muldivOp = funct3;
            if (!HASM || funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    if (in_inst[11:7] == 5'd0) dec.rdEn = 1'b0;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Next-state for the skid buffer; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = '{pc: in_pc, inst: in_inst, ctrl: dec};
          state_d = ONE;
        end
        ONE: begin
          if (accept && pop) begin
            main_d = '{pc: in_pc, inst: in_inst, ctrl: dec};
          end else if (accept) begin
            skid_d  = '{pc: in_pc, inst: in_inst, ctrl: dec};
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy and entry storage, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc      = main_q.pc;
  assign out_inst    = main_q.inst;
  assign rs1_addr    = main_q.inst[19:15];
  assign rs2_addr    = main_q.inst[24:20];
  assign rd_addr     = main_q.inst[11:7];
  assign rs1_en      = main_q.ctrl.rs1En;
  assign rs2_en      = main_q.ctrl.rs2En;
  assign rd_en       = main_q.ctrl.rdEn;
  assign alu_op      = main_q.ctrl.aluOp;
  assign alu_src_rs1 = main_q.ctrl.aluSrcRs1;
  assign alu_src_imm = main_q.ctrl.aluSrcImm;
  assign gen_type    = main_q.ctrl.genType;
  assign comp_type   = main_q.ctrl.compType;
  assign shift_type  = main_q.ctrl.shiftType;
  assign shift_imm   = main_q.ctrl.shiftImm;
  assign load_type   = main_q.ctrl.loadType;
  assign store_type  = main_q.ctrl.storeType;
  assign mem_read    = main_q.ctrl.memRead;
  assign mem_write   = main_q.ctrl.memWrite;
  assign inst_word   = main_q.ctrl.instWord;
  assign inst_branch = main_q.ctrl.instBranch;
  assign inst_jump   = main_q.ctrl.instJump;
  assign inst_lui    = main_q.ctrl.instLui;
  assign muldiv_en   = main_q.ctrl.muldivEn;
  assign muldiv_op   = main_q.ctrl.muldivOp;
  assign illegal     = main_q.ctrl.illegal;

  // A stalled entry must not change under EX while it waits
  holdStable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> ($stable(out_inst) && $stable(out_pc)));

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe. Three instances share the stimulus:
// [0] XLEN=64 with M, [1] XLEN=64 without M, [2] XLEN=32 with M.
module tb_id_decode_pipe;

  logic clk, rst_n, flush, inValid, outReady;
  logic [63:0] inPc;
  logic [31:0] inInst;

  logic [2:0]       inReady, outValid, rs1En, rs2En, rdEn, aluSrcRs1, aluSrcImm, shiftImm;
  logic [2:0]       memRead, memWrite, instWord, instBranch, instJump, instLui, muldivEn, illegal;
  logic [2:0][63:0] outPc;
  logic [2:0][31:0] outInst;
  logic [2:0][4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [2:0][2:0]  aluOp, genType, compType, shiftType, loadType, storeType, muldivOp;

  int compareCount = 0;
  int mismatchCount = 0;

  localparam logic [31:0] ADDI = 32'h00308293;
  localparam logic [31:0] ADD  = 32'h003100b3;
  localparam logic [31:0] SUB  = 32'h40628233;
  localparam logic [31:0] BEQ  = 32'h00208063;
  localparam logic [31:0] LW   = 32'h00812383;
  localparam logic [31:0] ORI  = 32'h00506313;
  localparam logic [31:0] ANDI = 32'h0070f413;
  localparam logic [31:0] MUL  = 32'h023100b3;
  localparam logic [31:0] ADDW = 32'h003100bb;
  localparam logic [31:0] LD   = 32'h0000b083;
  localparam logic [31:0] SLLI32 = 32'h02009093;
  localparam logic [31:0] SLLI31 = 32'h01f09093;

  for (genvar g = 0; g < 3; g++) begin : gDut
    id_decode_pipe #(
      .XLEN(g == 2 ? 32 : 64), .ENABLE_M(g == 1 ? 0 : 1), .PC_W(64)
    ) uDut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(inValid), .in_ready(inReady[g]), .in_pc(inPc), .in_inst(inInst),
      .out_valid(outValid[g]), .out_ready(outReady),
      .out_pc(outPc[g]), .out_inst(outInst[g]),
      .rs1_addr(rs1Addr[g]), .rs2_addr(rs2Addr[g]), .rd_addr(rdAddr[g]),
      .rs1_en(rs1En[g]), .rs2_en(rs2En[g]), .rd_en(rdEn[g]),
      .alu_op(aluOp[g]), .alu_src_rs1(aluSrcRs1[g]), .alu_src_imm(aluSrcImm[g]),
      .gen_type(genType[g]), .comp_type(compType[g]), .shift_type(shiftType[g]),
      .shift_imm(shiftImm[g]), .load_type(loadType[g]), .store_type(storeType[g]),
      .mem_read(memRead[g]), .mem_write(memWrite[g]), .inst_word(instWord[g]),
      .inst_branch(instBranch[g]), .inst_jump(instJump[g]), .inst_lui(instLui[g]),
      .muldiv_en(muldivEn[g]), .muldiv_op(muldivOp[g]), .illegal(illegal[g])
    );
  end

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic rdy, input logic fl);
    inValid  = v;
    inPc     = pc;
    inInst   = inst;
    outReady = rdy;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushOne(input logic [63:0] pc, input logic [31:0] inst);
    applyStimulus(1'b1, pc, inst, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Directed sequence covering reset, decode, backpressure, flush and async reset
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("resetOutValid", outValid[0], 0);
    checkOutput("resetInReady", inReady[0], 1);
    checkOutput("resetAluOp", aluOp[0], 0);
    checkOutput("resetOutInst", outInst[0], 0);
    checkOutput("resetGenType", genType[0], 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] addi decode");
    pushOne(64'h100, ADDI);
    checkOutput("addiValid", outValid[0], 1);
    checkOutput("addiRdEn", rdEn[0], 1);
    checkOutput("addiRdAddr", rdAddr[0], 5);
    checkOutput("addiRs1Addr", rs1Addr[0], 1);
    checkOutput("addiAluOp", aluOp[0], 3);
    checkOutput("addiGenType", genType[0], 6);
    checkOutput("addiSrcImm", aluSrcImm[0], 1);
    checkOutput("addiIllegal", illegal[0], 0);
    checkOutput("addiPc", outPc[0], 64'h100);
    tick();
    checkOutput("addiDrained", outValid[0], 0);

    $display("[TB] backpressure and ordering");
    applyStimulus(1'b1, 64'h10, ADD, 1'b0, 1'b0);
    tick();
    checkOutput("bpFirstValid", outValid[0], 1);
    checkOutput("bpFirstInst", outInst[0], ADD);
    checkOutput("bpReadyAfter1", inReady[0], 1);
    applyStimulus(1'b1, 64'h14, SUB, 1'b0, 1'b0);
    tick();
    checkOutput("bpReadyAfter2", inReady[0], 0);
    checkOutput("bpHeadStill", outInst[0], ADD);
    applyStimulus(1'b1, 64'h18, BEQ, 1'b0, 1'b0);
    tick();
    checkOutput("bpStallReady", inReady[0], 0);
    checkOutput("bpStallInst", outInst[0], ADD);
    checkOutput("bpStallPc", outPc[0], 64'h10);
    applyStimulus(1'b1, 64'h18, BEQ, 1'b1, 1'b0);
    tick();
    checkOutput("bpSecondInst", outInst[0], SUB);
    checkOutput("bpSubAluOp", aluOp[0], 4);
    checkOutput("bpReadyAgain", inReady[0], 1);
    tick();
    checkOutput("bpThirdInst", outInst[0], BEQ);
    checkOutput("beqBranch", instBranch[0], 1);
    checkOutput("beqCompType", compType[0], 2);
    checkOutput("beqGenType", genType[0], 7);
    checkOutput("beqRdEn", rdEn[0], 0);
    applyStimulus(1'b1, 64'h1c, LW, 1'b1, 1'b0);
    tick();
    checkOutput("bpFourthInst", outInst[0], LW);
    checkOutput("lwLoadType", loadType[0], 3);
    checkOutput("lwMemRead", memRead[0], 1);
    checkOutput("lwRdAddr", rdAddr[0], 7);
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("bpDrained", outValid[0], 0);

    $display("[TB] flush");
    applyStimulus(1'b1, 64'h200, ADDI, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h204, ORI, 1'b0, 1'b0);
    tick();
    checkOutput("flushPreReady", inReady[0], 0);
    checkOutput("flushPrePc", outPc[0], 64'h200);
    applyStimulus(1'b1, 64'h208, ANDI, 1'b0, 1'b1);
    tick();
    checkOutput("flushValid", outValid[0], 0);
    checkOutput("flushReady", inReady[0], 1);
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("flushNoReissue", outValid[0], 0);
    applyStimulus(1'b1, 64'h20c, ANDI, 1'b1, 1'b1);
    tick();
    checkOutput("flushDropsInput", outValid[0], 0);
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] parameter-dependent decode");
    pushOne(64'h300, MUL);
    checkOutput("mulMdEn", muldivEn[0], 1);
    checkOutput("mulMdOp", muldivOp[0], 0);
    checkOutput("mulIllegal", illegal[0], 0);
    checkOutput("mulAluOp", aluOp[0], 0);
    checkOutput("mulNoMIllegal", illegal[1], 1);
    checkOutput("mulNoMRdEn", rdEn[1], 0);
    checkOutput("mulNoMMdEn", muldivEn[1], 0);
    pushOne(64'h304, ADDW);
    checkOutput("addwWord", instWord[0], 1);
    checkOutput("addwIllegal64", illegal[0], 0);
    checkOutput("addwIllegal32", illegal[2], 1);
    checkOutput("addwWord32", instWord[2], 0);
    pushOne(64'h308, LD);
    checkOutput("ldLoadType", loadType[0], 4);
    checkOutput("ldIllegal32", illegal[2], 1);
    checkOutput("ldMemRead32", memRead[2], 0);
    pushOne(64'h30c, SLLI32);
    checkOutput("slliShiftType", shiftType[0], 1);
    checkOutput("slliShiftImm", shiftImm[0], 1);
    checkOutput("slliSrcImm", aluSrcImm[0], 0);
    checkOutput("slli32Illegal", illegal[2], 1);
    pushOne(64'h310, SLLI31);
    checkOutput("slli31Legal32", illegal[2], 0);
    checkOutput("slli31Shift32", shiftType[2], 1);
    pushOne(64'h314, 32'hffffffff);
    checkOutput("badOpIllegal", illegal[0], 1);
    checkOutput("badOpRs1En", rs1En[0], 0);
    checkOutput("badOpValid", outValid[0], 1);
    pushOne(64'h318, 32'h00000013);
    checkOutput("nopRdEn", rdEn[0], 0);
    checkOutput("nopRs1En", rs1En[0], 1);
    tick();

    $display("[TB] async reset while full");
    applyStimulus(1'b1, 64'h400, ADD, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h404, SUB, 1'b0, 1'b0);
    tick();
    checkOutput("rstPreReady", inReady[0], 0);
    applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidValid", outValid[0], 0);
    checkOutput("rstMidInst", outInst[0], 0);
    checkOutput("rstMidAluOp", aluOp[0], 0);
    checkOutput("rstMidRdEn", rdEn[0], 0);
    checkOutput("rstMidReady", inReady[0], 1);
    tick();
    rst_n = 1'b1;
    checkOutput("rstRelValid", outValid[0], 0);
    pushOne(64'h500, ADDI);
    checkOutput("rstNewValid", outValid[0], 1);
    checkOutput("rstNewPc", outPc[0], 64'h500);
    tick();
    checkOutput("rstNewDrained", outValid[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
Registered, parametrised successor to the combinational ID control decoder. It accepts one fetched instruction per cycle over a valid/ready handshake and decodes RV32I/RV64I, with optional M-extension support. It flags illegal encodings and presents a registered control bundle to EX through a 2-entry skid buffer. It sits between IF and EX, gives full-throughput backpressure, and supports a pipeline flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. At 32, the word ops (ALIW/ALW), ld/sd/lwu and shamt[5]=1 are illegal.
ENABLE_M, 1, 1 = decode M-extension ops (funct7=0000001 on AL/ALW); 0 = those encodings are illegal.
PC_W, 64, width of the pc field carried alongside the instruction.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill all buffered entries and any same-cycle input
in_valid  in  1  IF has an instruction
in_ready  out  1  decode can accept
in_pc  in  PC_W  instruction pc
in_inst  in  32  instruction word
out_valid  out  1  control bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  PC_W  registered pc
out_inst  out  32  registered instruction
rs1_addr/rs2_addr/rd_addr  out  5 each  inst[19:15]/[24:20]/[11:7]
rs1_en/rs2_en/rd_en  out  1 each  register-use enables; rd_en forced 0 when rd_addr=0
alu_op  out  3  0 none, 3 add, 4 sub/compare, 5 xor, 6 or, 7 and
alu_src_rs1  out  1  operand A is rs1; 0 = pc (auipc, jal)
alu_src_imm  out  1  operand B is immediate
gen_type  out  3  0 none, 3 S, 4 U, 5 J, 6 I, 7 B
comp_type  out  3  2 beq, 3 bne, 4 blt/slt(i), 5 bltu/sltu(i), 6 bge, 7 bgeu
shift_type  out  3  1 sll, 3 sllw, 5 srl, 7 srlw, 4 sra, 6 sraw
shift_imm  out  1  shift amount comes from the immediate
load_type  out  3  1 lb, 5 lbu, 2 lh, 6 lhu, 3 lw, 7 lwu, 4 ld
store_type  out  3  4 sb, 5 sh, 6 sw, 7 sd
mem_read/mem_write  out  1 each  load/store
inst_word/inst_branch/inst_jump/inst_lui  out  1 each  type flags
muldiv_en  out  1  M-extension op
muldiv_op  out  3  funct3 of the M op
illegal  out  1  undecodable or disallowed encoding

Behaviour:
- Decode is a combinational function of in_inst. The result is captured with in_pc/in_inst on acceptance (in_valid & in_ready & ~flush). Latency is exactly 1 cycle from acceptance to out_valid.
- Storage is a main register M and a skid register S. Occupancy states are EMPTY (M and S invalid), ONE (M valid), TWO (M and S valid).
- in_ready = ~S_valid, registered-derived, with no combinational path from out_ready.
- Pop = out_valid & out_ready.
- EMPTY + accept -> ONE.
- ONE + accept + pop -> ONE (M reloaded).
- ONE + accept + no pop -> TWO (new entry into S).
- ONE + pop + no accept -> EMPTY.
- TWO + pop -> ONE (S moves to M, S invalid). An accept cannot occur in TWO.
- Order is strictly FIFO; out_* always reflect M.
- flush has priority over everything: next state is EMPTY, any same-cycle input is dropped, and a same-cycle pop is still counted by EX but is not reissued.
- Reset (async assert, sync deassert by the system): state EMPTY, out_valid=0, all bundle outputs 0, in_ready=1. Reset mid-stream discards all entries.
- Entry data is held stable while out_valid & ~out_ready (verified by assertion).
- Illegal decode covers:
  - an unknown opcode;
  - bad funct3/funct7 combos for the listed ops;
  - XLEN/ENABLE_M disallowed encodings.
  On illegal: illegal=1; rd_en/rs*_en/mem_read/mem_write/muldiv_en=0; all type fields 0. The entry still flows through the buffer.
- Legal field mapping:
  - add-class ops, auipc, jumps and mem ops -> alu_op=3.
  - branch/slt/sub -> alu_op=4.
  - gen_type=6 for jalr, loads and non-shift immediate ALU ops.
  - shift_imm=1 for immediate shifts; shift_imm and alu_src_imm are mutually exclusive.
- An M op sets alu_op=0 and muldiv_en=1; inst_word=1 for the W variants.
- Zero-value fields are used when not applicable (e.g. comp_type=0 for add).

Test Plan:
- Reset, then addi x5,x1,3 (0x00308293) with out_ready=1 -> next cycle out_valid=1, rd_en=1, rd_addr=5, alu_op=3, gen_type=6, alu_src_imm=1, illegal=0.
- Back-to-back 4 instructions with out_ready=0 -> accepts 2, in_ready=0 after the 2nd. Raise out_ready -> outputs in order, 1 per cycle, no loss or duplication.
- State TWO, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
- ENABLE_M=0, mul x1,x2,x3 (0x023100b3) -> illegal=1, rd_en=0, muldiv_en=0. ENABLE_M=1 -> muldiv_en=1, muldiv_op=0, illegal=0.
- XLEN=32: addw (0x003100bb), ld (0x0000b083) and slli with shamt=32 -> illegal=1. At XLEN=64 they decode with inst_word=1, load_type=4, and shift_type=1 with shift_imm=1 respectively.
- rst_n asserted asynchronously mid-cycle while in TWO -> out_valid falls immediately, all outputs 0; after release in_ready=1 and the first new accept appears 1 cycle later.
